// File: rtl/rx_phy_pkg.sv
// rx_phy_pkg: shared RX symbol constants, lane geometry and sync FSM encoding
package rx_phy_pkg;
  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] IDLE_SYM = 8'h7C;
  localparam int NUM_LANES = 4;
  localparam int LANE_W = $clog2(NUM_LANES);
  typedef enum logic {SEARCH = 1'b0, ACTIVE = 1'b1} state_e;
endpackage

// File: rtl/rx_sync_ctrl_if.sv
// rx_sync_ctrl_if: byte input and forwarded-lane outputs of the RX sync controller
interface rx_sync_ctrl_if;
  import rx_phy_pkg::*;
  logic [7:0] byte_in;
  logic byte_strobe;
  logic active;
  logic [7:0] data_out;
  logic valid_out;
  logic [LANE_W-1:0] lane_sel;
  logic [NUM_LANES-1:0] lane_valid;
  logic sync_lost;
  modport master (output byte_in, byte_strobe,
                  input active, data_out, valid_out, lane_sel, lane_valid, sync_lost);
  modport slave (input byte_in, byte_strobe,
                 output active, data_out, valid_out, lane_sel, lane_valid, sync_lost);
endinterface

// File: rtl/rx_sync_ctrl.sv
// rx_sync_ctrl: COM-run sync acquisition, COM/IDLE filtering and round-robin lane scheduling
module rx_sync_ctrl
  import rx_phy_pkg::*;
#(
  parameter logic [7:0] COM_SYMBOL = COM_SYM,
  parameter logic [7:0] IDLE_SYMBOL = IDLE_SYM,
  parameter int COM_THRESH = 4,
  parameter int MAX_GAP = 64
) (
  input logic clk_4f,
  input logic reset,
  rx_sync_ctrl_if.slave rx
);
  state_e state_q, state_d;
  logic [3:0] com_cnt_q, com_cnt_d, com_inc;
  logic [7:0] gap_cnt_q, gap_cnt_d, gap_inc;
  logic [LANE_W-1:0] lane_ptr_q, lane_ptr_d, lane_sel_q, lane_sel_d;
  logic [NUM_LANES-1:0] lane_valid_q, lane_valid_d;
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d, lost_q, lost_d;
  logic is_com, is_idle;
  assign is_com = rx.byte_in == COM_SYMBOL;
  assign is_idle = rx.byte_in == IDLE_SYMBOL;
  assign com_inc = com_cnt_q + 4'd1;
  assign gap_inc = gap_cnt_q + 8'd1;
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q <= SEARCH;
      com_cnt_q <= '0;
      gap_cnt_q <= '0;
      lane_ptr_q <= '0;
      lane_sel_q <= '0;
      lane_valid_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      com_cnt_q <= com_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      lane_ptr_q <= lane_ptr_d;
      lane_sel_q <= lane_sel_d;
      lane_valid_q <= lane_valid_d;
      data_q <= data_d;
      valid_q <= valid_d;
      lost_q <= lost_d;
    end
  end
  always_comb begin
    state_d = state_q;
    com_cnt_d = com_cnt_q;
    gap_cnt_d = gap_cnt_q;
    lane_ptr_d = lane_ptr_q;
    lane_sel_d = lane_sel_q;
    lane_valid_d = '0;
    data_d = data_q;
    valid_d = 1'b0;
    lost_d = 1'b0;
    if (rx.byte_strobe) begin
      if (state_q == SEARCH) begin
        com_cnt_d = is_com ? com_inc : '0;
        if (is_com && com_inc == 4'(COM_THRESH)) begin
          state_d = ACTIVE;
          com_cnt_d = '0;
          gap_cnt_d = '0;
          lane_ptr_d = '0;
        end
      end else if (is_com) begin
        // COM wins over gap expiry and realigns the lane schedule
        gap_cnt_d = '0;
        lane_ptr_d = '0;
      end else if (gap_inc == 8'(MAX_GAP)) begin
        state_d = SEARCH;
        lost_d = 1'b1;
        com_cnt_d = '0;
        gap_cnt_d = '0;
        lane_ptr_d = '0;
      end else begin
        gap_cnt_d = gap_inc;
        if (!is_idle) begin
          data_d = rx.byte_in;
          valid_d = 1'b1;
          lane_sel_d = lane_ptr_q;
          lane_valid_d = NUM_LANES'(1) << lane_ptr_q;
          lane_ptr_d = lane_ptr_q + LANE_W'(1);
        end
      end
    end
  end
  assign rx.active = state_q == ACTIVE;
  assign rx.data_out = data_q;
  assign rx.valid_out = valid_q;
  assign rx.lane_sel = lane_sel_q;
  assign rx.lane_valid = lane_valid_q;
  assign rx.sync_lost = lost_q;
endmodule

// File: tb/tb_rx_sync_ctrl.sv
// tb_rx_sync_ctrl: scoreboard bench for rx_sync_ctrl with MAX_GAP=8
module tb_rx_sync_ctrl;
  typedef struct {
    logic [7:0] d;
    logic [1:0] l;
  } exp_t;
  logic clk_4f = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  rx_sync_ctrl_if ifc ();
  rx_sync_ctrl #(.COM_THRESH(4), .MAX_GAP(8)) dut (.clk_4f(clk_4f), .reset(reset), .rx(ifc.slave));
  always #5 clk_4f = ~clk_4f;
  always @(negedge clk_4f) begin
    if (ifc.valid_out === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: data=%h lane=%0d, required no valid", ifc.data_out, ifc.lane_sel);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (ifc.data_out !== e.d || ifc.lane_sel !== e.l || ifc.lane_valid !== (4'b0001 << e.l)) begin
          bad++;
          $display("FAIL fwd_byte: got data=%h lane=%0d lv=%b, required data=%h lane=%0d lv=%b",
                   ifc.data_out, ifc.lane_sel, ifc.lane_valid, e.d, e.l, 4'b0001 << e.l);
        end
      end
    end
  end
  task automatic send(input logic [7:0] b, input bit fwd, input logic [1:0] ln);
    @(negedge clk_4f);
    if (fwd) exp_q.push_back('{b, ln});
    ifc.byte_in = b;
    ifc.byte_strobe = 1'b1;
  endtask
  task automatic idle();
    @(negedge clk_4f);
    ifc.byte_strobe = 1'b0;
  endtask
  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d bytes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset();
    ifc.byte_in = 8'h00;
    ifc.byte_strobe = 1'b0;
    #12;
    total++;
    if ({ifc.active, ifc.data_out, ifc.valid_out, ifc.lane_sel, ifc.lane_valid, ifc.sync_lost} !== 17'd0) begin
      bad++;
      $display("FAIL reset_state: act=%b d=%h v=%b ls=%0d lv=%b sl=%b, required all zero", ifc.active,
               ifc.data_out, ifc.valid_out, ifc.lane_sel, ifc.lane_valid, ifc.sync_lost);
    end
    @(negedge clk_4f);
    reset = 1'b1;
  endtask
  task automatic test_broken_run();
    send(8'hBC, 0, 0); send(8'hBC, 0, 0); send(8'hBC, 0, 0); send(8'h7C, 0, 0);
    send(8'hBC, 0, 0); send(8'hBC, 0, 0); send(8'hBC, 0, 0);
    idle();
    total++;
    if (ifc.active !== 1'b0) begin
      bad++;
      $display("FAIL broken_run: active=%b, required 0", ifc.active);
    end
    send(8'hBC, 0, 0);
    idle();
    total++;
    if (ifc.active !== 1'b1) begin
      bad++;
      $display("FAIL broken_run_acquire: active=%b, required 1", ifc.active);
    end
  endtask
  task automatic test_round_robin();
    send(8'h01, 1, 0); send(8'h7C, 0, 0); send(8'h02, 1, 1);
    send(8'h03, 1, 2); send(8'h04, 1, 3); send(8'h05, 1, 0);
    idle(); idle();
    check_drained("round_robin");
  endtask
  task automatic test_realign();
    send(8'h66, 1, 1); send(8'hBC, 0, 0); send(8'h55, 1, 0);
    idle(); idle();
    check_drained("realign");
  endtask
  task automatic test_sync_loss();
    send(8'hBC, 0, 0);
    for (int i = 0; i < 7; i++) send(8'h7C, 0, 0);
    send(8'h7C, 0, 0);
    total++;
    if (ifc.active !== 1'b1 || ifc.sync_lost !== 1'b0) begin
      bad++;
      $display("FAIL loss_early: active=%b sync_lost=%b, required 1 0", ifc.active, ifc.sync_lost);
    end
    idle();
    total++;
    if (ifc.active !== 1'b0 || ifc.sync_lost !== 1'b1) begin
      bad++;
      $display("FAIL loss_edge: active=%b sync_lost=%b, required 0 1", ifc.active, ifc.sync_lost);
    end
    idle();
    total++;
    if (ifc.sync_lost !== 1'b0) begin
      bad++;
      $display("FAIL loss_pulse: sync_lost=%b, required 0", ifc.sync_lost);
    end
    for (int i = 0; i < 4; i++) send(8'hBC, 0, 0);
    for (int i = 0; i < 7; i++) send(8'h7C, 0, 0);
    send(8'hBC, 0, 0);
    send(8'h77, 1, 0);
    idle(); idle();
    total++;
    if (ifc.active !== 1'b1 || ifc.sync_lost !== 1'b0) begin
      bad++;
      $display("FAIL com_at_gap_edge: active=%b sync_lost=%b, required 1 0", ifc.active, ifc.sync_lost);
    end
    for (int i = 0; i < 6; i++) send(8'h80 + 8'(i), 1, 2'(i + 1));
    send(8'h99, 0, 0);
    idle();
    total++;
    if (ifc.active !== 1'b0 || ifc.sync_lost !== 1'b1 || ifc.valid_out !== 1'b0) begin
      bad++;
      $display("FAIL data_loss: active=%b sync_lost=%b valid=%b, required 0 1 0", ifc.active, ifc.sync_lost,
               ifc.valid_out);
    end
    idle();
    check_drained("sync_loss");
  endtask
  task automatic test_acquire();
    for (int i = 0; i < 3; i++) send(8'hBC, 0, 0);
    send(8'hBC, 0, 0);
    total++;
    if (ifc.active !== 1'b0) begin
      bad++;
      $display("FAIL acquire_early: active=%b, required 0", ifc.active);
    end
    send(8'h12, 1, 0);
    total++;
    if (ifc.active !== 1'b1) begin
      bad++;
      $display("FAIL acquire: active=%b, required 1", ifc.active);
    end
    idle(); idle();
    check_drained("acquire");
  endtask
  task automatic test_reset_mid();
    send(8'hA5, 0, 0);
    @(posedge clk_4f);
    #1;
    total++;
    if (ifc.valid_out !== 1'b1 || ifc.data_out !== 8'hA5 || ifc.lane_sel !== 2'd1) begin
      bad++;
      $display("FAIL mid_pre: valid=%b data=%h lane=%0d, required 1 a5 1", ifc.valid_out, ifc.data_out,
               ifc.lane_sel);
    end
    #1;
    reset = 1'b0;
    ifc.byte_strobe = 1'b0;
    #1;
    total++;
    if ({ifc.active, ifc.data_out, ifc.valid_out, ifc.lane_sel, ifc.lane_valid, ifc.sync_lost} !== 17'd0) begin
      bad++;
      $display("FAIL mid_reset: act=%b d=%h v=%b ls=%0d lv=%b sl=%b, required all zero", ifc.active,
               ifc.data_out, ifc.valid_out, ifc.lane_sel, ifc.lane_valid, ifc.sync_lost);
    end
    idle(); idle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) send(8'hBC, 0, 0);
    idle();
    total++;
    if (ifc.active !== 1'b0) begin
      bad++;
      $display("FAIL reacquire_3com: active=%b, required 0", ifc.active);
    end
    send(8'hBC, 0, 0);
    idle();
    total++;
    if (ifc.active !== 1'b1) begin
      bad++;
      $display("FAIL reacquire_4com: active=%b, required 1", ifc.active);
    end
    check_drained("reset_mid");
  endtask
  initial begin
    test_reset();
    test_broken_run();
    test_round_robin();
    test_realign();
    test_sync_loss();
    test_acquire();
    test_reset_mid();
    idle(); idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
